// File: rtl/cdc_debounce.sv
// cdc_debounce: qualifies an already-synchronized level over STABLE samples,
// producing a clean level, one-cycle edge strobes and a saturating rise count.
module cdc_debounce #(
  parameter int STABLE = 4,
  parameter int EW     = 8
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          in,
  input  logic          clr,
  output logic          out,
  output logic          rise,
  output logic          fall,
  output logic [EW-1:0] count
);

  localparam int CW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [EW-1:0] CMAX = '1;
  localparam logic [EW-1:0] ONE_E = EW'(1);

  if (STABLE < 1) begin : g_bad_stable
    $fatal(1, "cdc_debounce: STABLE must be >= 1");
  end
  if (EW < 1) begin : g_bad_ew
    $fatal(1, "cdc_debounce: EW must be >= 1");
  end

  typedef enum logic [1:0] {
    LOW,
    QUAL_HI,
    HIGH,
    QUAL_LO
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise_d;
  logic          fall_d;
  logic          out_d;
  logic [EW-1:0] count_d;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (in) begin
          if (STABLE == 1) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = QUAL_HI;
            cnt_d   = ONE_C;
          end
        end
      end
      QUAL_HI: begin
        if (!in) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      HIGH: begin
        if (!in) begin
          if (STABLE == 1) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            state_d = QUAL_LO;
            cnt_d   = ONE_C;
          end
        end
      end
      QUAL_LO: begin
        if (in) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output level follows the accepted side, so it is a function of next state.
  always_comb begin
    out_d = (state_d == HIGH) || (state_d == QUAL_LO);
  end

  // A clear coinciding with a rise keeps that rise as the first event.
  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = rise_d ? ONE_E : '0;
    end else if (rise_d && (count != CMAX)) begin
      count_d = count + ONE_E;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      count <= '0;
    end else begin
      out   <= out_d;
      rise  <= rise_d;
      fall  <= fall_d;
      count <= count_d;
    end
  end

endmodule
